// File: rtl/hazard_detect.sv
// hazard_detect: ID-stage load-use / mult-div hazard unit with branch flush
// and a saturating stall-cycle counter.
module hazard_detect #(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 3,
    parameter int STAT_W         = 32
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [31:0]       IFID_Instruction,
    input  logic              IDEX_MemRead,
    input  logic [4:0]        IDEX_RegT,
    input  logic              Branch_Taken,
    output logic              PC_Write,
    output logic              IFID_Write,
    output logic              IDEX_Bubble,
    output logic              IFID_Flush,
    output logic              MulDiv_Busy,
    output logic [STAT_W-1:0] Stall_Cycles
);
    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_LATENCY - 1);
    localparam bit MD_MULTI = MULDIV_LATENCY > 1;

    logic [0:0]       state;
    logic [CNT_W-1:0] md_cnt;
    logic [5:0]       op, funct;
    logic [4:0]       rs, rt;
    logic             uses_rs, uses_rt, is_md, is_mfhl;
    logic             load_use, md_hold, stall, busy;
    logic             unused_bits;

    assign op          = IFID_Instruction[31:26];
    assign rs          = IFID_Instruction[25:21];
    assign rt          = IFID_Instruction[20:16];
    assign funct       = IFID_Instruction[5:0];
    assign unused_bits = ^IFID_Instruction[15:6];

    assign uses_rs = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
    assign uses_rt = op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B;
    assign is_md   = op == 6'h00 && funct[5:2] == 4'b0110;
    assign is_mfhl = op == 6'h00 && (funct == 6'h10 || funct == 6'h12);

    assign load_use = IDEX_MemRead && IDEX_RegT != 5'd0 &&
                      ((uses_rs && rs == IDEX_RegT) || (uses_rt && rt == IDEX_RegT));
    assign busy     = state == MD_BUSY;
    assign md_hold  = busy && (is_md || is_mfhl);
    // Reset forces the pipeline to free-run regardless of what is in ID.
    assign stall    = RESET && (load_use || md_hold);

    assign PC_Write    = !stall;
    assign IFID_Write  = !stall;
    assign IDEX_Bubble = stall;
    assign IFID_Flush  = RESET && !stall && Branch_Taken;
    assign MulDiv_Busy = RESET && busy;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
        end else if (state == MD_IDLE) begin
            if (MD_MULTI && is_md && !stall) begin
                state  <= MD_BUSY;
                md_cnt <= MD_LOAD;
            end
        end else begin
            md_cnt <= md_cnt - 1'b1;
            state  <= md_cnt == CNT_W'(1) ? MD_IDLE : MD_BUSY;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)
            Stall_Cycles <= '0;
        else if (stall && !(&Stall_Cycles))
            Stall_Cycles <= Stall_Cycles + 1'b1;
    end
endmodule

// File: tb/tb_hazard_detect.sv
// tb_hazard_detect: directed + random checks of hazard_detect against a
// cycle-level reference model (busy-cycles-left counter, saturating totals).
module tb_hazard_detect;
    localparam int LAT = 4;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] instr = '0;
    logic        memread = 1'b0;
    logic [4:0]  regt = '0;
    logic        br = 1'b0;

    logic        pc_w, ifid_w, bub, flush, busy;
    logic [31:0] sc;
    logic        pc_w_s, ifid_w_s, bub_s, flush_s, busy_s;
    logic [3:0]  sc_s;

    int n_chk = 0, n_pass = 0;
    int busy_left = 0;
    longint cnt = 0;
    int cnt_s = 0;

    hazard_detect #(.MULDIV_LATENCY(LAT), .CNT_W(3), .STAT_W(32)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .IFID_Instruction(instr), .IDEX_MemRead(memread),
        .IDEX_RegT(regt), .Branch_Taken(br), .PC_Write(pc_w), .IFID_Write(ifid_w),
        .IDEX_Bubble(bub), .IFID_Flush(flush), .MulDiv_Busy(busy), .Stall_Cycles(sc)
    );

    hazard_detect #(.MULDIV_LATENCY(LAT), .CNT_W(3), .STAT_W(4)) dut_s (
        .CLOCK(CLOCK), .RESET(RESET), .IFID_Instruction(instr), .IDEX_MemRead(memread),
        .IDEX_RegT(regt), .Branch_Taken(br), .PC_Write(pc_w_s), .IFID_Write(ifid_w_s),
        .IDEX_Bubble(bub_s), .IFID_Flush(flush_s), .MulDiv_Busy(busy_s), .Stall_Cycles(sc_s)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int f);
        return (rs << 21) | (rt << 16) | (rd << 11) | f;
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return (op << 26) | (rs << 21) | (rt << 16) | (imm & 32'hFFFF);
    endfunction

    function automatic bit m_is_md();
        int op = int'(instr >> 26), f = int'(instr & 63);
        return op == 0 && f >= 24 && f <= 27;
    endfunction

    function automatic bit m_stall();
        int op = int'(instr >> 26);
        int rs = int'((instr >> 21) & 31), rt = int'((instr >> 16) & 31);
        int f  = int'(instr & 63);
        bit uses_rs = !(op == 2 || op == 3 || op == 15);
        bit uses_rt = op == 0 || op == 4 || op == 5 || op == 43;
        bit mfhl = op == 0 && (f == 16 || f == 18);
        bit lu = memread && regt != 0 &&
                 ((uses_rs && rs == int'(regt)) || (uses_rt && rt == int'(regt)));
        if (!RESET) return 0;
        return lu || (busy_left > 0 && (m_is_md() || mfhl));
    endfunction

    task automatic drive(string tag, logic [31:0] i, logic mr, logic [4:0] rt, logic b);
        bit s;
        instr = i; memread = mr; regt = rt; br = b;
        #1;
        s = m_stall();
        check({tag, ".pc"}, 32'(pc_w), 32'(!s));
        check({tag, ".ifid"}, 32'(ifid_w), 32'(!s));
        check({tag, ".bubble"}, 32'(bub), 32'(s));
        check({tag, ".flush"}, 32'(flush), 32'(RESET && !s && b));
        check({tag, ".busy"}, 32'(busy), 32'(RESET && busy_left > 0));
        check({tag, ".cycles"}, sc, 32'(cnt));
        check({tag, ".cycles4"}, 32'(sc_s), 32'(cnt_s));
    endtask

    task automatic tick();
        bit s = m_stall();
        bit md = m_is_md();
        @(posedge CLOCK);
        if (RESET) begin
            if (s) begin
                if (cnt < 64'hFFFF_FFFF) cnt++;
                if (cnt_s < 15) cnt_s++;
            end
            if (busy_left > 0) busy_left--;
            else if (md && !s && LAT > 1) busy_left = LAT - 1;
        end
        @(negedge CLOCK);
    endtask

    task automatic assert_reset();
        RESET = 1'b0;
        busy_left = 0; cnt = 0; cnt_s = 0;
    endtask

    initial begin
        logic [31:0] add_t0, mult, mflo, nop;
        longint base;
        int ops[9]    = '{0, 2, 3, 15, 4, 5, 35, 43, 8};
        int functs[8] = '{32, 24, 25, 26, 27, 16, 18, 34};
        add_t0 = rtype(8, 10, 9, 32);
        mult   = rtype(8, 9, 0, 24);
        mflo   = rtype(0, 0, 10, 18);
        nop    = '0;

        assert_reset();
        @(negedge CLOCK);
        drive("rst", add_t0, 1, 8, 1);
        check("rst.pc_lit", 32'(pc_w), 1);
        check("rst.flush_lit", 32'(flush), 0);
        tick();
        RESET = 1'b1;

        drive("t1a", add_t0, 1, 8, 0);
        check("t1a.bubble_lit", 32'(bub), 1);
        check("t1a.pc_lit", 32'(pc_w), 0);
        tick();
        drive("t1b", add_t0, 0, 8, 0);
        check("t1b.bubble_lit", 32'(bub), 0);
        tick();

        drive("t2a", rtype(0, 0, 9, 32), 1, 0, 0);
        check("t2a.pc_lit", 32'(pc_w), 1);
        tick();
        drive("t2b", itype(15, 0, 8, 16'h1234), 1, 8, 0);
        check("t2b.pc_lit", 32'(pc_w), 1);
        tick();

        drive("t4a", itype(4, 1, 2, 5), 0, 0, 1);
        check("t4a.flush_lit", 32'(flush), 1);
        tick();
        drive("t4b", itype(4, 8, 2, 5), 1, 8, 1);
        check("t4b.flush_lit", 32'(flush), 0);
        check("t4b.bubble_lit", 32'(bub), 1);
        tick();

        base = cnt;
        drive("t3i", mult, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive("t3h", mflo, 0, 0, 0);
            check("t3h.busy_lit", 32'(busy), 1);
            check("t3h.pc_lit", 32'(pc_w), 0);
            tick();
        end
        drive("t3r", mflo, 0, 0, 0);
        check("t3r.busy_lit", 32'(busy), 0);
        check("t3r.pc_lit", 32'(pc_w), 1);
        check("t3r.delta", sc - 32'(base), 3);
        tick();

        drive("t5a", mult, 0, 0, 0);
        tick();
        drive("t5b", nop, 0, 0, 0);
        tick();
        assert_reset();
        drive("t5r", mflo, 0, 0, 0);
        check("t5r.busy_lit", 32'(busy), 0);
        check("t5r.cycles_lit", sc, 0);
        tick();
        RESET = 1'b1;
        drive("t5c", mflo, 0, 0, 0);
        check("t5c.pc_lit", 32'(pc_w), 1);
        tick();

        for (int k = 0; k < 20; k++) begin
            drive("t6", add_t0, 1, 8, 0);
            tick();
        end
        drive("t6e", nop, 0, 0, 0);
        check("t6e.sat_lit", 32'(sc_s), 15);
        check("t6e.wide_lit", sc, 32'(cnt));
        tick();

        for (int k = 0; k < 400; k++) begin
            int op = ops[$urandom_range(0, 8)];
            int f  = functs[$urandom_range(0, 7)];
            drive("rnd", itype(op, $urandom_range(0, 3), $urandom_range(0, 3), (1 << 11) | f),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
